aes_core_arbiter: RTL and testbench



---
 rtl/aes_core_arbiter.sv | 148 ++++++++++++++
 tb/tb_aes_core_arbiter.sv | 157 +++++++++++++++
 2 files changed

// File: rtl/aes_core_arbiter.sv
// aes_core_arbiter: round-robin sharing of one byte-serial AES-128 core between two clients
module aes_core_arbiter #(
  parameter int TIMEOUT = 1023,
  parameter int CNT_W   = 10
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         req0,
  input  logic [127:0] key0,
  input  logic [127:0] msg0,
  input  logic         req1,
  input  logic [127:0] key1,
  input  logic [127:0] msg1,
  output logic         gnt0,
  output logic         gnt1,
  output logic         done0,
  output logic         done1,
  output logic [127:0] result,
  output logic         err,
  output logic         core_rst,
  output logic [7:0]   core_key,
  output logic [7:0]   core_msg,
  input  logic [127:0] core_result,
  input  logic         core_done
);
  typedef enum logic [1:0] {IDLE, LOAD, RUN} state_t;
  state_t       state_q, state_d;
  logic         last_q, last_d, sel_q, sel_d;
  logic [127:0] key_sh_q, key_sh_d, msg_sh_q, msg_sh_d;
  logic [3:0]   byte_q, byte_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic         gnt0_q, gnt0_d, gnt1_q, gnt1_d, done0_q, done0_d, done1_q, done1_d;
  logic [127:0] result_q, result_d;
  logic         err_q, err_d, core_rst_q, core_rst_d;
  logic [7:0]   core_key_q, core_key_d, core_msg_q, core_msg_d;
  logic         win, pick;
  logic [127:0] key_in, msg_in;
  // on a tie the client that did not win last time is picked
  assign win    = req0 | req1;
  assign pick   = (req0 & req1) ? ~last_q : req1;
  assign key_in = pick ? key1 : key0;
  assign msg_in = pick ? msg1 : msg0;
  always_comb begin
    state_d    = state_q;
    last_d     = last_q;
    sel_d      = sel_q;
    key_sh_d   = key_sh_q;
    msg_sh_d   = msg_sh_q;
    byte_d     = byte_q;
    cnt_d      = cnt_q;
    gnt0_d     = 1'b0;
    gnt1_d     = 1'b0;
    done0_d    = 1'b0;
    done1_d    = 1'b0;
    result_d   = result_q;
    err_d      = err_q;
    core_rst_d = core_rst_q;
    core_key_d = 8'h00;
    core_msg_d = 8'h00;
    case (state_q)
      IDLE: begin
        core_rst_d = ~win;
        if (win) begin
          sel_d      = pick;
          last_d     = pick;
          gnt0_d     = ~pick;
          gnt1_d     = pick;
          core_key_d = key_in[127:120];
          core_msg_d = msg_in[127:120];
          key_sh_d   = {key_in[119:0], 8'h00};
          msg_sh_d   = {msg_in[119:0], 8'h00};
          byte_d     = 4'd0;
          state_d    = LOAD;
        end
      end
      LOAD: begin
        if (byte_q == 4'd15) begin
          cnt_d   = '0;
          state_d = RUN;
        end else begin
          core_key_d = key_sh_q[127:120];
          core_msg_d = msg_sh_q[127:120];
          key_sh_d   = key_sh_q << 8;
          msg_sh_d   = msg_sh_q << 8;
          byte_d     = byte_q + 4'd1;
        end
      end
      RUN: begin
        cnt_d = cnt_q + 1'b1;
        if (core_done || cnt_q == CNT_W'(TIMEOUT)) begin
          done0_d    = ~sel_q;
          done1_d    = sel_q;
          err_d      = ~core_done;
          result_d   = core_done ? core_result : result_q;
          core_rst_d = 1'b1;
          state_d    = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      last_q     <= 1'b1;
      sel_q      <= 1'b0;
      key_sh_q   <= '0;
      msg_sh_q   <= '0;
      byte_q     <= '0;
      cnt_q      <= '0;
      gnt0_q     <= 1'b0;
      gnt1_q     <= 1'b0;
      done0_q    <= 1'b0;
      done1_q    <= 1'b0;
      result_q   <= '0;
      err_q      <= 1'b0;
      core_rst_q <= 1'b1;
      core_key_q <= '0;
      core_msg_q <= '0;
    end else begin
      state_q    <= state_d;
      last_q     <= last_d;
      sel_q      <= sel_d;
      key_sh_q   <= key_sh_d;
      msg_sh_q   <= msg_sh_d;
      byte_q     <= byte_d;
      cnt_q      <= cnt_d;
      gnt0_q     <= gnt0_d;
      gnt1_q     <= gnt1_d;
      done0_q    <= done0_d;
      done1_q    <= done1_d;
      result_q   <= result_d;
      err_q      <= err_d;
      core_rst_q <= core_rst_d;
      core_key_q <= core_key_d;
      core_msg_q <= core_msg_d;
    end
  end
  assign gnt0     = gnt0_q;
  assign gnt1     = gnt1_q;
  assign done0    = done0_q;
  assign done1    = done1_q;
  assign result   = result_q;
  assign err      = err_q;
  assign core_rst = core_rst_q;
  assign core_key = core_key_q;
  assign core_msg = core_msg_q;
endmodule

// File: tb/tb_aes_core_arbiter.sv
// tb_aes_core_arbiter: directed self-checking bench; the bench plays the AES core
module tb_aes_core_arbiter;
  logic         clk = 1'b0, rst = 1'b1;
  logic         req0 = 1'b0, req1 = 1'b0, core_done = 1'b0;
  logic [127:0] key0 = '0, msg0 = '0, key1 = '0, msg1 = '0, core_result = '0;
  logic         gnt0, gnt1, done0, done1, err, core_rst;
  logic [127:0] result;
  logic [7:0]   core_key, core_msg;
  int           nerr = 0, nchk = 0;
  localparam logic [127:0] K0 = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] M0 = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] R0 = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
  localparam logic [127:0] K1 = 128'hf0e1d2c3b4a5968778695a4b3c2d1e0f;
  localparam logic [127:0] M1 = 128'h0123456789abcdeffedcba9876543210;
  localparam logic [127:0] R1 = 128'hdeadbeef0badf00dcafebabe12345678;
  localparam logic [127:0] R2 = 128'h11111111222222223333333344444444;
  localparam logic [127:0] R3 = 128'ha5a5a5a55a5a5a5a0f0f0f0ff0f0f0f0;

  aes_core_arbiter #(.TIMEOUT(20), .CNT_W(10)) dut (
    .clk(clk), .rst(rst),
    .req0(req0), .key0(key0), .msg0(msg0),
    .req1(req1), .key1(key1), .msg1(msg1),
    .gnt0(gnt0), .gnt1(gnt1), .done0(done0), .done1(done1),
    .result(result), .err(err), .core_rst(core_rst),
    .core_key(core_key), .core_msg(core_msg),
    .core_result(core_result), .core_done(core_done)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    nchk++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // caller raises the request; returns at the negedge showing byte 15
  task automatic grant_load(input int c, input logic [127:0] k, input logic [127:0] m, input bit chg);
    @(negedge clk);
    check("gnt", {126'b0, gnt1, gnt0}, (c != 0) ? 128'd2 : 128'd1);
    check("core_rst_load", core_rst, 0);
    if (chg) key0 = '1;
    for (int i = 0; i < 16; i++) begin
      if (i > 0) @(negedge clk);
      if (i == 1) check("gnt_pulse", {gnt1, gnt0}, 0);
      check("core_key", core_key, k[127-8*i -: 8]);
      check("core_msg", core_msg, m[127-8*i -: 8]);
    end
  endtask

  task automatic finish_job(input int c, input logic [127:0] r, input int lat);
    repeat (lat) @(negedge clk);
    check("run_key_zero", {core_key, core_msg}, 0);
    core_result = r;
    core_done = 1'b1;
    @(negedge clk);
    check("done", {126'b0, done1, done0}, (c != 0) ? 128'd2 : 128'd1);
    check("result", result, r);
    check("err_ok", err, 0);
    check("core_rst_idle", core_rst, 1);
    core_done = 1'b0;
  endtask

  initial begin
    logic seen;
    repeat (3) @(negedge clk);
    check("rst_pulses", {gnt0, gnt1, done0, done1, err}, 0);
    check("rst_result", result, 0);
    check("rst_core_rst", core_rst, 1);
    check("rst_core_bytes", {core_key, core_msg}, 0);
    rst = 1'b0;
    // single FIPS-197 job
    req0 = 1'b1; key0 = K0; msg0 = M0;
    grant_load(0, K0, M0, 0);
    req0 = 1'b0;
    finish_job(0, R0, 3);
    @(negedge clk);
    check("done_pulse", {done1, done0}, 0);
    // tie after reset: 0, then 1, then 0 again
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    req0 = 1'b1; req1 = 1'b1; key1 = K1; msg1 = M1;
    grant_load(0, K0, M0, 0);
    finish_job(0, R1, 1);
    grant_load(1, K1, M1, 0);
    finish_job(1, R2, 2);
    grant_load(0, K0, M0, 0);
    req0 = 1'b0; req1 = 1'b0;
    finish_job(0, R3, 1);
    // timeout: RUN counts 0..20, done one cycle later
    @(negedge clk);
    req1 = 1'b1;
    grant_load(1, K1, M1, 0);
    req1 = 1'b0;
    repeat (21) @(negedge clk);
    check("to_not_yet", {done1, done0}, 0);
    @(negedge clk);
    check("to_done", {done1, done0}, 2'b10);
    check("to_err", err, 1);
    check("to_result_held", result, R3);
    req0 = 1'b1;
    grant_load(0, K0, M0, 0);
    req0 = 1'b0;
    finish_job(0, R0, 2);
    // operands captured at grant only
    @(negedge clk);
    req0 = 1'b1;
    grant_load(0, K0, M0, 1);
    req0 = 1'b0;
    finish_job(0, R1, 1);
    key0 = K0;
    // reset at RUN cycle 5
    @(negedge clk);
    req0 = 1'b1;
    grant_load(0, K0, M0, 0);
    req0 = 1'b0;
    repeat (6) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("mid_rst_pulses", {gnt0, gnt1, done0, done1, err}, 0);
    check("mid_rst_result", result, 0);
    check("mid_rst_core_rst", core_rst, 1);
    check("mid_rst_bytes", {core_key, core_msg}, 0);
    seen = 1'b0;
    repeat (30) begin
      @(negedge clk);
      seen = seen | done0 | done1 | gnt0 | gnt1 | ~core_rst;
    end
    check("no_activity_after_rst", seen, 0);
    req1 = 1'b1;
    grant_load(1, K1, M1, 0);
    req1 = 1'b0;
    finish_job(1, R2, 1);
    // stray core_done in IDLE
    @(negedge clk);
    core_done = 1'b1;
    core_result = R3;
    seen = 1'b0;
    repeat (5) begin
      @(negedge clk);
      seen = seen | done0 | done1 | gnt0 | gnt1 | ~core_rst;
    end
    check("stray_done_ignored", seen, 0);
    check("stray_result_held", result, R2);
    core_done = 1'b0;
    req0 = 1'b1;
    grant_load(0, K0, M0, 0);
    req0 = 1'b0;
    finish_job(0, R0, 4);
    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end
endmodule
